// File: rtl/mem_line_master.sv
// Line-granular memory master: ID-tagged transaction table, one read and one write issue slot.
// Define MEM_RAW_CHECK_EN to refuse reads that hit an outstanding write line address.
module mem_line_master #(
  parameter int unsigned NPHYS            = 56,
  parameter int unsigned CACHE_LINE_SIZE  = 512,
  parameter int unsigned ACACHE_LINE_SIZE = 6,
  parameter int unsigned TSIZE            = 5,
  parameter int unsigned NTRANS           = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  // client read
  input  logic                                cl_rd_req,
  input  logic [NPHYS-ACACHE_LINE_SIZE-1:0]   cl_rd_addr,
  output logic                                cl_rd_ack,
  // client write
  input  logic                                cl_wr_req,
  input  logic [NPHYS-ACACHE_LINE_SIZE-1:0]   cl_wr_addr,
  input  logic [CACHE_LINE_SIZE-1:0]          cl_wr_data,
  output logic                                cl_wr_ack,
  // client return
  output logic                                cl_rdata_valid,
  output logic [CACHE_LINE_SIZE-1:0]          cl_rdata,
  output logic [NPHYS-ACACHE_LINE_SIZE-1:0]   cl_rdata_addr,
  input  logic                                cl_rdata_ack,
  output logic                                wr_idle,
  output logic                                err_unexp,
  // memory read address
  output logic [NPHYS-ACACHE_LINE_SIZE-1:0]   mem_raddr,
  output logic [TSIZE-1:0]                    mem_raddr_trans,
  output logic                                mem_raddr_req,
  input  logic                                mem_raddr_ack,
  // memory read data
  input  logic [CACHE_LINE_SIZE-1:0]          mem_rdata,
  input  logic [TSIZE-1:0]                    mem_rdata_trans,
  input  logic                                mem_rdata_req,
  output logic                                mem_rdata_ack,
  // memory write
  output logic [NPHYS-ACACHE_LINE_SIZE-1:0]   mem_waddr,
  output logic [TSIZE-1:0]                    mem_waddr_trans,
  output logic [CACHE_LINE_SIZE-1:0]          mem_wdata,
  output logic                                mem_waddr_req,
  input  logic                                mem_waddr_ack,
  input  logic [TSIZE-1:0]                    mem_wdata_trans,
  input  logic                                mem_wdata_done
);

  localparam int unsigned LaW  = NPHYS - ACACHE_LINE_SIZE;
  localparam int unsigned IdxW = (NTRANS > 1) ? $clog2(NTRANS) : 1;

  // Transaction table
  logic [NTRANS-1:0] busy_q, busy_d;
  logic [NTRANS-1:0] is_wr_q, is_wr_d;
  logic [LaW-1:0]    addr_q [NTRANS];

  // Issue registers and return buffer
  logic                       rd_iss_valid_q, wr_iss_valid_q;
  logic [LaW-1:0]             rd_iss_addr_q, wr_iss_addr_q;
  logic [TSIZE-1:0]           rd_iss_id_q, wr_iss_id_q;
  logic [CACHE_LINE_SIZE-1:0] wr_iss_data_q;
  logic                       rb_valid_q, rb_valid_d;
  logic [CACHE_LINE_SIZE-1:0] rb_data_q;
  logic [LaW-1:0]             rb_addr_q;
  logic                       err_q;

  logic [TSIZE-1:0] first_id, second_id, rd_alloc_id;
  logic             first_found, second_found;
  logic [IdxW-1:0]  wr_slot, rd_slot, rd_idx, wd_idx;
  logic             wr_accept, rd_accept, rd_id_ok, raw_hazard;
  logic             rdata_xfer, rd_hit, rd_err, wd_hit, wd_err;

  // Lowest and next-lowest free IDs; a write always takes the lowest.
  always_comb begin
    first_id     = '0;
    second_id    = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    for (int unsigned i = 0; i < NTRANS; i++) begin
      if (!busy_q[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_id    = TSIZE'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_id    = TSIZE'(i);
        end
      end
    end
  end

`ifdef MEM_RAW_CHECK_EN
  always_comb begin
    raw_hazard = cl_wr_req && (cl_wr_addr == cl_rd_addr);
    if (wr_iss_valid_q && (wr_iss_addr_q == cl_rd_addr)) raw_hazard = 1'b1;
    for (int unsigned i = 0; i < NTRANS; i++) begin
      if (busy_q[i] && is_wr_q[i] && (addr_q[i] == cl_rd_addr)) raw_hazard = 1'b1;
    end
  end
`else
  assign raw_hazard = 1'b0;
`endif

  assign cl_wr_ack   = reset_n && first_found && (!wr_iss_valid_q || mem_waddr_ack);
  assign wr_accept   = cl_wr_req && cl_wr_ack;
  assign rd_id_ok    = wr_accept ? second_found : first_found;
  assign rd_alloc_id = wr_accept ? second_id : first_id;
  assign cl_rd_ack   = reset_n && rd_id_ok && (!rd_iss_valid_q || mem_raddr_ack) && !raw_hazard;
  assign rd_accept   = cl_rd_req && cl_rd_ack;
  assign wr_slot     = first_id[IdxW-1:0];
  assign rd_slot     = rd_alloc_id[IdxW-1:0];

  // Responses: only a busy entry of the matching type is accepted; anything else is flagged.
  assign mem_rdata_ack = reset_n && (!rb_valid_q || cl_rdata_ack);
  assign rdata_xfer    = mem_rdata_req && mem_rdata_ack;
  assign rd_idx        = mem_rdata_trans[IdxW-1:0];
  assign wd_idx        = mem_wdata_trans[IdxW-1:0];
  assign rd_hit        = rdata_xfer && (32'(mem_rdata_trans) < NTRANS) &&
                         busy_q[rd_idx] && !is_wr_q[rd_idx];
  assign rd_err        = rdata_xfer && !rd_hit;
  assign wd_hit        = mem_wdata_done && (32'(mem_wdata_trans) < NTRANS) &&
                         busy_q[wd_idx] && is_wr_q[wd_idx];
  assign wd_err        = mem_wdata_done && !wd_hit;

  always_comb begin
    busy_d  = busy_q;
    is_wr_d = is_wr_q;
    if (rd_hit) busy_d[rd_idx] = 1'b0;
    if (wd_hit) busy_d[wd_idx] = 1'b0;
    if (wr_accept) begin
      busy_d[wr_slot]  = 1'b1;
      is_wr_d[wr_slot] = 1'b1;
    end
    if (rd_accept) begin
      busy_d[rd_slot]  = 1'b1;
      is_wr_d[rd_slot] = 1'b0;
    end
  end

  always_comb begin
    rb_valid_d = rb_valid_q;
    if (rd_hit)            rb_valid_d = 1'b1;
    else if (cl_rdata_ack) rb_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      is_wr_q <= '0;
      for (int unsigned i = 0; i < NTRANS; i++) addr_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      is_wr_q <= is_wr_d;
      if (wr_accept) addr_q[wr_slot] <= cl_wr_addr;
      if (rd_accept) addr_q[rd_slot] <= cl_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_iss_valid_q <= 1'b0;
      rd_iss_addr_q  <= '0;
      rd_iss_id_q    <= '0;
    end else if (rd_accept) begin
      rd_iss_valid_q <= 1'b1;
      rd_iss_addr_q  <= cl_rd_addr;
      rd_iss_id_q    <= rd_alloc_id;
    end else if (mem_raddr_ack) begin
      rd_iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_iss_valid_q <= 1'b0;
      wr_iss_addr_q  <= '0;
      wr_iss_id_q    <= '0;
      wr_iss_data_q  <= '0;
    end else if (wr_accept) begin
      wr_iss_valid_q <= 1'b1;
      wr_iss_addr_q  <= cl_wr_addr;
      wr_iss_id_q    <= first_id;
      wr_iss_data_q  <= cl_wr_data;
    end else if (mem_waddr_ack) begin
      wr_iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
      rb_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rb_valid_q <= rb_valid_d;
      err_q      <= rd_err || wd_err;
      if (rd_hit) begin
        rb_data_q <= mem_rdata;
        rb_addr_q <= addr_q[rd_idx];
      end
    end
  end

  assign cl_rdata_valid  = rb_valid_q;
  assign cl_rdata        = rb_data_q;
  assign cl_rdata_addr   = rb_addr_q;
  assign err_unexp       = err_q;
  assign wr_idle         = !(|(busy_q & is_wr_q)) && !wr_iss_valid_q;
  assign mem_raddr       = rd_iss_addr_q;
  assign mem_raddr_trans = rd_iss_id_q;
  assign mem_raddr_req   = rd_iss_valid_q;
  assign mem_waddr       = wr_iss_addr_q;
  assign mem_waddr_trans = wr_iss_id_q;
  assign mem_wdata       = wr_iss_data_q;
  assign mem_waddr_req   = wr_iss_valid_q;

endmodule
